// File: rtl/adder_tree_seq_ctrl_pkg.sv
// Shared state type and width helpers for the adder-tree sequencer
// and the parent that sizes the adder tree around it.
package adder_tree_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_ISSUE,
        SEQ_DRAIN,
        SEQ_DONE
    } seq_state_e;

    function automatic int acc_width(
        input int n,
        input int dataw,
        input int chunks
    );
        return $clog2(n) + dataw + $clog2(chunks) + 1;
    endfunction

    function automatic int cidx_width(input int chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

endpackage

// File: rtl/adder_tree_seq_ctrl_result.sv
// Job-total holding register: loads once per job and keeps
// the value stable until the consumer accepts it.
module adder_tree_seq_ctrl_result
    import adder_tree_seq_ctrl_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic [W-1:0] data_o,
    output logic         valid_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o  <= '0;
            valid_o <= 1'b0;
        end else if (load_i) begin
            data_o  <= data_i;
            valid_o <= 1'b1;
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/adder_tree_seq_ctrl.sv
// Issues one chunk per cycle to a shared adder tree and folds the
// returned partial sums into a single signed total per job.
module adder_tree_seq_ctrl
    import adder_tree_seq_ctrl_pkg::*;
#(
    parameter int N          = 256,
    parameter int DATAW      = 8,
    parameter int NUM_CHUNKS = 4,
    parameter int PIPES      = 0,
    parameter int TREE_W     = $clog2(N) + DATAW,
    parameter int ACC_W      = TREE_W + $clog2(NUM_CHUNKS) + 1,
    localparam int CIDX_W    = cidx_width(NUM_CHUNKS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              start_i,
    output logic              start_ready_o,
    output logic [CIDX_W-1:0] chunk_idx_o,
    output logic              tree_valid_o,
    input  logic              tree_valid_i,
    input  logic [TREE_W-1:0] tree_sum_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              sum_valid_o,
    input  logic              sum_ready_i,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(NUM_CHUNKS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CHUNKS - 1);
    localparam logic [CNT_W-1:0] ALL_RET  = CNT_W'(NUM_CHUNKS);

    if (NUM_CHUNKS < 1 || PIPES < 0 || PIPES > 4) begin : g_bad_cfg
        $error("adder_tree_seq_ctrl: unsupported NUM_CHUNKS/PIPES");
    end

    seq_state_e       state;
    seq_state_e       state_n;
    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] ret_cnt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [ACC_W-1:0] acc_final;
    logic             in_job;
    logic             issue_fire;
    logic             ret_fire;
    logic             res_load;

    assign in_job     = (state == SEQ_ISSUE) || (state == SEQ_DRAIN);
    assign issue_fire = (state == SEQ_ISSUE) && en_i;
    assign ret_fire   = in_job && tree_valid_i;
    assign acc_sum    = acc + {{(ACC_W-TREE_W){tree_sum_i[TREE_W-1]}},
                               tree_sum_i};
    assign acc_final  = ret_fire ? acc_sum : acc;
    assign res_load   = (state == SEQ_DRAIN) && (ret_cnt == ALL_RET);
    assign busy_o     = (state != SEQ_IDLE);

    always_comb begin
        state_n       = state;
        start_ready_o = 1'b0;
        tree_valid_o  = 1'b0;
        chunk_idx_o   = '0;
        unique case (state)
            SEQ_IDLE: begin
                start_ready_o = 1'b1;
                if (start_i) state_n = SEQ_ISSUE;
            end
            SEQ_ISSUE: begin
                chunk_idx_o  = issue_cnt[CIDX_W-1:0];
                tree_valid_o = en_i;
                if (en_i && issue_cnt == LAST_IDX) state_n = SEQ_DRAIN;
            end
            SEQ_DRAIN: begin
                if (res_load) state_n = SEQ_DONE;
            end
            SEQ_DONE: begin
                if (sum_ready_i) state_n = SEQ_IDLE;
            end
            default: state_n = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= SEQ_IDLE;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            acc       <= '0;
        end else begin
            state <= state_n;
            if (state == SEQ_IDLE && start_i) begin
                issue_cnt <= '0;
                ret_cnt   <= '0;
                acc       <= '0;
            end else begin
                if (issue_fire) issue_cnt <= issue_cnt + 1'b1;
                if (ret_fire) begin
                    acc     <= acc_sum;
                    ret_cnt <= ret_cnt + 1'b1;
                end
            end
        end
    end

    adder_tree_seq_ctrl_result #(
        .W(ACC_W)
    ) u_result (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (res_load),
        .data_i  (acc_final),
        .ready_i (sum_ready_i),
        .data_o  (sum_o),
        .valid_o (sum_valid_o)
    );

`ifndef SYNTHESIS
    a_ret_le_issue: assert property (@(posedge clk_i) disable iff (rst_i)
        ret_cnt <= issue_cnt);
    a_sum_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        sum_valid_o && !sum_ready_i |=> $stable(sum_o));
    // IDLE returns are legal: the tail of a job abandoned by reset.
    a_stray_ret: assert property (@(posedge clk_i) disable iff (rst_i)
        state == SEQ_DONE |-> !tree_valid_i);
`endif

endmodule

// File: tb/tb_adder_tree_seq_ctrl.sv
// Scoreboard bench: a behavioural tree with run-time latency feeds the
// sequencer; totals are predicted as the plain sum of all job terms.
module tb_adder_tree_seq_ctrl;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int NC  = 4;
    localparam int TW  = 10;
    localparam int AW  = 13;
    localparam int AWB = 11;

    typedef struct {
        int sum;
        int lat;
        int acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- instance A: four chunks ----------------
    logic          en;
    logic          start;
    logic          start_ready;
    logic [1:0]    cidx;
    logic          tv_o;
    logic          tv_i;
    logic [TW-1:0] tsum;
    logic [AW-1:0] sum;
    logic          sum_v;
    logic          sum_ready;
    logic          busy;

    adder_tree_seq_ctrl #(
        .N(N), .DATAW(DW), .NUM_CHUNKS(NC), .PIPES(2)
    ) u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en),
        .start_i       (start),
        .start_ready_o (start_ready),
        .chunk_idx_o   (cidx),
        .tree_valid_o  (tv_o),
        .tree_valid_i  (tv_i),
        .tree_sum_i    (tsum),
        .sum_o         (sum),
        .sum_valid_o   (sum_v),
        .sum_ready_i   (sum_ready),
        .busy_o        (busy)
    );

    int   terms [NC][N];
    int   csum  [NC];
    int   lat = 0;
    logic pv [4];
    int   ps [4];

    always @(posedge clk) begin
        pv[0] <= tv_o;
        ps[0] <= csum[cidx];
        for (int i = 1; i < 4; i++) begin
            pv[i] <= pv[i-1];
            ps[i] <= ps[i-1];
        end
    end

    always_comb begin
        tv_i = tv_o;
        tsum = TW'(csum[cidx]);
        if (lat != 0) begin
            tv_i = pv[lat-1];
            tsum = TW'(ps[lat-1]);
        end
    end

    exp_t q[$];

    always begin : mon_a
        exp_t e;
        logic prev_v;
        int   tv_cnt;
        logic [AW-1:0] held;
        @(negedge clk);
        #2;
        if (rst) begin
            prev_v = 1'b0;
            tv_cnt = 0;
        end else begin
            if (tv_o) tv_cnt++;
            if (sum_v && !prev_v) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    if (q[0].lat >= 0)
                        chk("latency", cyc - q[0].acc, q[0].lat);
                    chk("tree_valid_cycles", tv_cnt, NC);
                end
                held = sum;
            end else if (sum_v) begin
                chk("sum_hold", int'($signed(sum)), int'($signed(held)));
            end
            if (sum_v && sum_ready) begin
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("sum", int'($signed(sum)), e.sum);
                end
                tv_cnt = 0;
            end
            prev_v = sum_v;
        end
    end

    task automatic load_terms(input bit rnd);
        for (int c = 0; c < NC; c++) begin
            csum[c] = 0;
            for (int k = 0; k < N; k++) begin
                if (rnd) terms[c][k] = int'($urandom_range(255)) - 128;
                csum[c] += terms[c][k];
            end
        end
    endtask

    task automatic start_job(input int l, input int pause);
        exp_t e;
        int   n;
        lat   = l;
        e.sum = 0;
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < N; k++)
                e.sum += terms[c][k];
        @(negedge clk);
        start = 1'b1;
        en    = 1'b1;
        #1;
        n = 0;
        while (!start_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("start_accept", int'(start_ready), 1);
        e.lat = NC + l + 1 + pause;
        e.acc = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_job(input int l, input bit rnd, input int pause,
                           input int rdy_dly);
        int n;
        load_terms(rnd);
        sum_ready = (rdy_dly == 0);
        start_job(l, pause);
        if (pause > 0) begin
            @(negedge clk);
            @(negedge clk);
            en = 1'b0;
            repeat (pause) begin
                #1;
                chk("pause_idx", int'(cidx), 2);
                chk("pause_tree_valid", int'(tv_o), 0);
                @(negedge clk);
            end
            en = 1'b1;
        end
        n = 0;
        while (!sum_v && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("result_seen", int'(sum_v), 1);
        if (rdy_dly > 0) begin
            start = 1'b1;
            repeat (rdy_dly) begin
                #1;
                chk("done_start_ready", int'(start_ready), 0);
                chk("done_busy", int'(busy), 1);
                @(negedge clk);
            end
            sum_ready = 1'b1;
            @(negedge clk);
            start = 1'b0;
            #1;
            chk("idle_after_ready", int'(start_ready), 1);
        end
        sum_ready = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic reset_mid_drain();
        exp_t e;
        load_terms(1'b1);
        sum_ready = 1'b1;
        start_job(2, 0);
        repeat (4) @(negedge clk);
        chk("drain_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("rst_start_ready", int'(start_ready), 1);
        chk("rst_tree_valid", int'(tv_o), 0);
        chk("rst_chunk_idx", int'(cidx), 0);
        chk("rst_sum", int'(sum), 0);
        chk("rst_sum_valid", int'(sum_v), 0);
        chk("rst_busy", int'(busy), 0);
        e = q.pop_back();
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("post_rst_idle", int'(busy), 0);
        chk("post_rst_no_result", int'(sum_v), 0);
    endtask

    // ---------------- instance B: single chunk ----------------
    logic           start_b;
    logic           start_ready_b;
    logic [0:0]     cidx_b;
    logic           tv_o_b;
    logic           tv_i_b;
    logic [TW-1:0]  tsum_b;
    logic [AWB-1:0] sum_b;
    logic           sum_v_b;
    logic           ready_b;
    logic           busy_b;
    logic           en_b;
    int             csum_b = 0;

    assign tv_i_b = tv_o_b;
    assign tsum_b = TW'(csum_b);

    adder_tree_seq_ctrl #(
        .N(N), .DATAW(DW), .NUM_CHUNKS(1), .PIPES(0)
    ) u_dut_b (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en_b),
        .start_i       (start_b),
        .start_ready_o (start_ready_b),
        .chunk_idx_o   (cidx_b),
        .tree_valid_o  (tv_o_b),
        .tree_valid_i  (tv_i_b),
        .tree_sum_i    (tsum_b),
        .sum_o         (sum_b),
        .sum_valid_o   (sum_v_b),
        .sum_ready_i   (ready_b),
        .busy_o        (busy_b)
    );

    int qb[$];

    always begin : mon_b
        int exp_v;
        @(negedge clk);
        #2;
        if (!rst && sum_v_b && ready_b) begin
            if (qb.size() == 0) begin
                chk("b_unexpected", 1, 0);
            end else begin
                exp_v = qb.pop_front();
                chk("b_sum", int'($signed(sum_b)), exp_v);
            end
        end
    end

    task automatic run_b(input int v);
        int n;
        int acc_at;
        int tot;
        tot = 0;
        for (int k = 0; k < N; k++) tot += v;
        csum_b = tot;
        qb.push_back(tot);
        @(negedge clk);
        start_b = 1'b1;
        #1;
        chk("b_start_ready", int'(start_ready_b), 1);
        acc_at = cyc + 1;
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        while (!sum_v_b && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b_result_seen", int'(sum_v_b), 1);
        chk("b_latency", cyc - acc_at, 2);
        repeat (3) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int spec_sums [NC];
        en        = 1'b1;
        start     = 1'b0;
        sum_ready = 1'b1;
        start_b   = 1'b0;
        ready_b   = 1'b1;
        en_b      = 1'b1;
        for (int c = 0; c < NC; c++) begin
            csum[c] = 0;
            for (int k = 0; k < N; k++) terms[c][k] = 0;
        end
        repeat (5) @(negedge clk);
        #1;
        chk("reset_start_ready", int'(start_ready), 1);
        chk("reset_tree_valid", int'(tv_o), 0);
        chk("reset_chunk_idx", int'(cidx), 0);
        chk("reset_sum", int'(sum), 0);
        chk("reset_sum_valid", int'(sum_v), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_b_busy", int'(busy_b), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        spec_sums = '{10, -3, 100, -128};
        for (int c = 0; c < NC; c++) begin
            terms[c][0] = spec_sums[c];
            for (int k = 1; k < N; k++) terms[c][k] = 0;
        end
        run_job(0, 1'b0, 0, 0);
        run_job(2, 1'b0, 0, 0);
        run_job(0, 1'b0, 3, 0);
        run_job(1, 1'b0, 0, 5);
        reset_mid_drain();
        run_job(2, 1'b0, 0, 0);
        for (int i = 0; i < 12; i++)
            run_job(int'($urandom_range(4)), 1'b1,
                    int'($urandom_range(3)), int'($urandom_range(2)));

        run_b(127);
        run_b(-128);
        repeat (5) @(negedge clk);
        chk("queues_drained", q.size() + qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
